// File: rtl/fifo_write_status_if.sv
// Producer / memory-write / read-controller signal bundle for fifo_write_status.
// i_* are driven into the write-status block, o_* are produced by it.
interface fifo_write_status_if #(
    parameter int WORD_SIZE = 10,
    parameter int PTR       = 3
);
    logic                 i_fifo_wr;
    logic [WORD_SIZE-1:0] i_data_in;
    logic                 i_pop;
    logic                 i_peak_clr;

    logic                 o_push;
    logic [PTR-1:0]       o_wr_ptr;
    logic [WORD_SIZE-1:0] o_wr_data;
    logic [PTR:0]         o_occupancy;
    logic                 o_fifo_empty;
    logic                 o_fifo_full;
    logic                 o_almost_full;
    logic                 o_almost_empty;
    logic                 o_overflow_err;
    logic                 o_underflow_err;
    logic [PTR:0]         o_peak_occ;

    modport master (
        output i_fifo_wr, i_data_in, i_pop, i_peak_clr,
        input  o_push, o_wr_ptr, o_wr_data, o_occupancy, o_fifo_empty, o_fifo_full,
               o_almost_full, o_almost_empty, o_overflow_err, o_underflow_err, o_peak_occ
    );

    modport slave (
        input  i_fifo_wr, i_data_in, i_pop, i_peak_clr,
        output o_push, o_wr_ptr, o_wr_data, o_occupancy, o_fifo_empty, o_fifo_full,
               o_almost_full, o_almost_empty, o_overflow_err, o_underflow_err, o_peak_occ
    );
endinterface

// File: rtl/fifo_write_status.sv
// FIFO write-side controller: push strobe, write pointer, occupancy and status/error flags.
// Optional peak-occupancy tracker enabled by defining FIFO_PEAK_EN.
module fifo_write_status #(
    parameter int MEM_SIZE        = 8,
    parameter int WORD_SIZE       = 10,
    parameter int PTR             = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                clk,
    input  logic                reset,
    fifo_write_status_if.slave  bus
);
    localparam int OW = PTR + 1;
    localparam logic [PTR:0]   OCC_MAX  = OW'(MEM_SIZE);
    localparam logic [PTR:0]   AF_TH    = OW'(ALMOST_FULL_TH);
    localparam logic [PTR:0]   AE_TH    = OW'(ALMOST_EMPTY_TH);
    localparam logic [PTR-1:0] PTR_LAST = PTR'(MEM_SIZE - 1);

    logic [PTR-1:0] r_wr_ptr;
    logic [PTR:0]   r_occ;
    logic           r_empty;
    logic           r_full;
    logic           r_almost_full;
    logic           r_almost_empty;
    logic           r_overflow_err;
    logic           r_underflow_err;

    logic           w_push;
    logic [PTR-1:0] w_wr_ptr_next;
    logic [PTR:0]   w_occ_next;
    logic           w_empty_next;
    logic           w_full_next;
    logic           w_almost_full_next;
    logic           w_almost_empty_next;
    logic           w_overflow_set;
    logic           w_underflow_set;

    // A write while full is only accepted when a pop frees a slot in the same cycle.
    assign w_push = !reset && bus.i_fifo_wr && (!r_full || bus.i_pop);

    // State register: occupancy encodes EMPTY (0) / ACTIVE / FULL (MEM_SIZE).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_occ           <= '0;
            r_empty         <= 1'b1;
            r_full          <= 1'b0;
            r_almost_full   <= 1'b0;
            r_almost_empty  <= 1'b1;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_wr_ptr        <= w_wr_ptr_next;
            r_occ           <= w_occ_next;
            r_empty         <= w_empty_next;
            r_full          <= w_full_next;
            r_almost_full   <= w_almost_full_next;
            r_almost_empty  <= w_almost_empty_next;
            r_overflow_err  <= r_overflow_err  || w_overflow_set;
            r_underflow_err <= r_underflow_err || w_underflow_set;
        end
    end

    // Next-state: occupancy saturates at 0; push+pop at empty is a read-side bypass.
    always_comb begin
        w_occ_next    = r_occ;
        w_wr_ptr_next = r_wr_ptr;
        unique case ({w_push, bus.i_pop})
            2'b10:   w_occ_next = r_occ + 1'b1;
            2'b01:   w_occ_next = (r_occ == '0) ? r_occ : r_occ - 1'b1;
            default: w_occ_next = r_occ;
        endcase
        if (w_push) begin
            w_wr_ptr_next = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
        end
    end

    // Status decode from next occupancy so flags line up with the registered count.
    always_comb begin
        w_empty_next        = (w_occ_next == '0);
        w_full_next         = (w_occ_next == OCC_MAX);
        w_almost_full_next  = (w_occ_next >= AF_TH);
        w_almost_empty_next = (w_occ_next <= AE_TH);
        w_overflow_set      = bus.i_fifo_wr && r_full && !bus.i_pop;
        w_underflow_set     = bus.i_pop && !w_push && (r_occ == '0);
    end

`ifdef FIFO_PEAK_EN
    logic [PTR:0] r_peak_occ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_peak_occ <= '0;
        end else if (bus.i_peak_clr) begin
            r_peak_occ <= w_occ_next;
        end else if (w_occ_next > r_peak_occ) begin
            r_peak_occ <= w_occ_next;
        end
    end

    assign bus.o_peak_occ = r_peak_occ;
`else
    logic w_unused_peak_clr;
    assign w_unused_peak_clr = bus.i_peak_clr;
    assign bus.o_peak_occ    = '0;
`endif

    assign bus.o_push          = w_push;
    assign bus.o_wr_ptr        = r_wr_ptr;
    assign bus.o_wr_data       = bus.i_data_in;
    assign bus.o_occupancy     = r_occ;
    assign bus.o_fifo_empty    = r_empty;
    assign bus.o_fifo_full     = r_full;
    assign bus.o_almost_full   = r_almost_full;
    assign bus.o_almost_empty  = r_almost_empty;
    assign bus.o_overflow_err  = r_overflow_err;
    assign bus.o_underflow_err = r_underflow_err;
endmodule

// File: doc/fifo_write_status.md
Name: fifo_write_status

Overview:
Write-side control and status stage of the FIFO.
- Generates the push strobe and write pointer for the FIFO memory.
- Tracks occupancy using the pop strobe returned by the read-side controller.
- Produces fifo_empty, which the read controller consumes, plus full, almost-full/almost-empty and sticky error flags for the flow-control layer.
- Sits between the producer interface, the memory write port and the read controller.

Parameters:
MEM_SIZE, 8, number of FIFO entries; need not be a power of two
WORD_SIZE, 10, data word width in bits
PTR, 3, write pointer width; must satisfy 2^PTR >= MEM_SIZE
ALMOST_FULL_TH, 6, occupancy at or above which almost_full is asserted
ALMOST_EMPTY_TH, 2, occupancy at or below which almost_empty is asserted

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
fifo_wr  input  1  producer write request
data_in  input  WORD_SIZE  producer write data
pop  input  1  read strobe from the read controller; one entry leaves this cycle
push  output  1  memory write enable, combinational
wr_ptr  output  PTR  memory write address, registered
wr_data  output  WORD_SIZE  memory write data, equal to data_in
occupancy  output  PTR+1  current number of stored entries, registered
fifo_empty  output  1  occupancy == 0, registered
fifo_full  output  1  occupancy == MEM_SIZE, registered
almost_full  output  1  occupancy >= ALMOST_FULL_TH, registered
almost_empty  output  1  occupancy <= ALMOST_EMPTY_TH, registered
overflow_err  output  1  sticky; a write was refused while full
underflow_err  output  1  sticky; a pop arrived with nothing stored and no write in the same cycle
peak_occ  output  PTR+1  maximum occupancy since reset or clear (optional feature)
peak_clr  input  1  synchronous clear of peak_occ (optional feature)

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - wr_ptr=0, occupancy=0, fifo_empty=1, fifo_full=0.
  - almost_empty=1, almost_full=0.
  - overflow_err=0, underflow_err=0, peak_occ=0.
  - While reset is high, push is forced to 0.
- push = fifo_wr & (!fifo_full | pop). A write while full is accepted only if a pop occurs in the same cycle.
- wr_data = data_in, combinational, with no latency. The memory captures wr_data at wr_ptr on the clk edge where push=1.
- wr_ptr:
  - Increments by 1 on each cycle where push=1.
  - When wr_ptr == MEM_SIZE-1, it wraps to 0.
  - Otherwise it holds.
- Occupancy update (next value from the push/pop pair):
  - push=1, pop=0: +1
  - push=0, pop=1, occupancy>0: -1
  - push=1, pop=1: unchanged
  - push=0, pop=1, occupancy=0: unchanged (saturates at 0) and underflow_err set
  - Occupancy never exceeds MEM_SIZE.
- Pop while empty with a simultaneous write is legal: the read controller bypasses the data, so occupancy stays 0 and no error is raised.
- Overflow: fifo_wr=1, fifo_full=1, pop=0 means no push, wr_ptr and occupancy unchanged, and overflow_err set.
- Error flags are sticky and are cleared only by reset.
- Status flags are computed from the next occupancy and registered. They are therefore valid in the same cycle the updated occupancy appears, one clk after the causing event.
- The status FSM is encoded in occupancy:
  - EMPTY (0): goes to ACTIVE on push without pop.
  - ACTIVE (1..MEM_SIZE-1): goes to FULL on push without pop at MEM_SIZE-1; goes to EMPTY on pop without push at 1.
  - FULL (MEM_SIZE): goes to ACTIVE on pop without push.

Optional Feature:
Macro FIFO_PEAK_EN.
- Defined:
  - peak_occ is a registered maximum of occupancy, updated each cycle as max(peak_occ, next occupancy).
  - peak_clr=1 loads peak_occ with the next occupancy; peak_clr has priority over the max update.
  - Reset clears peak_occ to 0.
- Not defined:
  - peak_occ is tied to 0 and peak_clr is ignored.
  - The ports remain present so the bench is identical in both builds.

Test Plan:
1. Reset released, 8 consecutive fifo_wr with pop=0 -> wr_ptr goes 1..7 then 0; occupancy=8; fifo_full=1; almost_full asserted when occupancy reaches 6; fifo_empty deasserts after the first write.
2. Full FIFO, fifo_wr=1, pop=0 for 1 cycle -> push=0, wr_ptr and occupancy unchanged, overflow_err=1 and stays 1 through 5 further idle cycles.
3. Full FIFO, fifo_wr=1 and pop=1 together -> push=1, occupancy stays 8, wr_ptr advances by 1, overflow_err stays 0.
4. Empty FIFO, pop=1 with fifo_wr=0 -> occupancy stays 0, underflow_err=1. Repeat with fifo_wr=1 and pop=1 -> occupancy 0, no new error.
5. Occupancy 5, reset pulsed high mid-cycle (between edges) -> outputs return to reset values immediately without waiting for clk; push=0 while reset is high.
6. FIFO_PEAK_EN defined: fill to 7, drain to 2 -> peak_occ=7; peak_clr pulse -> peak_occ=2; undefined build -> peak_occ=0 throughout.
